// File: rtl/hazard_stall_unit.sv
// Load-use hazard detection and stall control, with shadow EX/MEM/WB records feeding forwarding.
// Define HAZARD_BRANCH_STALL_EN to add stalls for branches resolved in ID.
module hazard_stall_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IDRS,
  input  logic [4:0]  IDRT,
  input  logic [4:0]  IDRD,
  input  logic        IDRegWrite,
  input  logic        IDMemRead,
  input  logic        IDBranch,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        Bubble,
  output logic        PR3RegWrite,
  output logic [4:0]  RDfromPR3,
  output logic        PR4RegWrite,
  output logic [4:0]  RDfromPR4,
  output logic [15:0] StallCycles
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic [4:0] rd;
  } stage_t;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  stage_t      ex_reg, mem_reg, wb_reg;
  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [15:0] stall_cnt;
  logic [1:0]  need;
  logic        stall;
  logic        ex_match, mem_match;
  logic        unused_ok;

  // Register 0 is hardwired, so it can never be a producer worth waiting on.
  assign ex_match  = (ex_reg.rd != 5'd0)  && ((ex_reg.rd == IDRS)  || (ex_reg.rd == IDRT));
  assign mem_match = (mem_reg.rd != 5'd0) && ((mem_reg.rd == IDRS) || (mem_reg.rd == IDRT));

  // Rules are applied in increasing N so the last assignment is the largest.
  always_comb begin
    need = 2'd0;
    if (ex_reg.mem_read && ex_match)
      need = 2'd1;
`ifdef HAZARD_BRANCH_STALL_EN
    if (IDBranch) begin
      if ((ex_reg.reg_write && !ex_reg.mem_read && ex_match) || (mem_reg.mem_read && mem_match))
        need = 2'd1;
      if (ex_reg.mem_read && ex_match)
        need = 2'd2;
    end
`endif
  end

  assign unused_ok = ^{IDBranch, mem_match, mem_reg.mem_read, wb_reg.mem_read};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Hazard inputs are only sampled in RUN; STALL simply counts down.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        cnt_next = 2'd0;
        if (need > 2'd1) begin
          state_next = STALL;
          cnt_next   = need - 2'd1;
        end
      end
      STALL: begin
        cnt_next = cnt_reg - 2'd1;
        if (cnt_reg == 2'd1)
          state_next = RUN;
      end
      default: begin
        state_next = RUN;
        cnt_next   = 2'd0;
      end
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state_reg)
      RUN:     stall = (need != 2'd0);
      STALL:   stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign PCWrite   = !stall;
  assign IFIDWrite = !stall;
  assign Bubble    = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_reg    <= '0;
      mem_reg   <= '0;
      wb_reg    <= '0;
      stall_cnt <= 16'd0;
    end else begin
      wb_reg  <= mem_reg;
      mem_reg <= ex_reg;
      ex_reg  <= stall ? stage_t'('0) : stage_t'({IDRegWrite, IDMemRead, IDRD});
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign PR3RegWrite = mem_reg.reg_write;
  assign RDfromPR3   = mem_reg.rd;
  assign PR4RegWrite = wb_reg.reg_write;
  assign RDfromPR4   = wb_reg.rd;
  assign StallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: instruction-history model checked every cycle plus directed literal checks.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  IDRS = '0, IDRT = '0, IDRD = '0;
  logic        IDRegWrite = 1'b0, IDMemRead = 1'b0, IDBranch = 1'b0;
  logic        PCWrite, IFIDWrite, Bubble;
  logic        PR3RegWrite, PR4RegWrite;
  logic [4:0]  RDfromPR3, RDfromPR4;
  logic [15:0] StallCycles;

  int compared   = 0;
  int mismatched = 0;
  bit cmp_en     = 1'b0;

`ifdef HAZARD_BRANCH_STALL_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  hazard_stall_unit dut (
    .clk(clk), .rst(rst),
    .IDRS(IDRS), .IDRT(IDRT), .IDRD(IDRD),
    .IDRegWrite(IDRegWrite), .IDMemRead(IDMemRead), .IDBranch(IDBranch),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .Bubble(Bubble),
    .PR3RegWrite(PR3RegWrite), .RDfromPR3(RDfromPR3),
    .PR4RegWrite(PR4RegWrite), .RDfromPR4(RDfromPR4),
    .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  // Model: history of issued instructions (0 = EX, 1 = MEM, 2 = WB), stall cycles still owed, stall total.
  typedef struct packed {
    logic       rw;
    logic       mr;
    logic [4:0] rd;
  } rec_t;

  rec_t m_rec [3];
  int   m_left = 0;
  int   m_cnt  = 0;
  int   m_bias = 0;
  int   m_n;
  bit   m_stall;

  function automatic int need_of(rec_t ex, rec_t mem, logic [4:0] rs, logic [4:0] rt, logic br);
    int  n;
    bit  exm, memm;
    exm  = (ex.rd != 0) && (ex.rd == rs || ex.rd == rt);
    memm = (mem.rd != 0) && (mem.rd == rs || mem.rd == rt);
    n = 0;
    if (ex.mr && exm) n = 1;
    if (BR_EN && br) begin
      if (ex.rw && !ex.mr && exm && n < 1) n = 1;
      if (mem.mr && memm && n < 1) n = 1;
      if (ex.mr && exm) n = 2;
    end
    return n;
  endfunction

  always_comb begin
    m_n     = need_of(m_rec[0], m_rec[1], IDRS, IDRT, IDBranch);
    m_stall = (m_left > 0) || (m_n > 0);
  end

  initial begin
    for (int i = 0; i < 3; i++) m_rec[i] = '0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rec[0] <= '0;
      m_rec[1] <= '0;
      m_rec[2] <= '0;
      m_left   <= 0;
      m_cnt    <= 0;
    end else begin
      m_rec[2] <= m_rec[1];
      m_rec[1] <= m_rec[0];
      m_rec[0] <= m_stall ? rec_t'('0) : rec_t'({IDRegWrite, IDMemRead, IDRD});
      if (m_left > 0)    m_left <= m_left - 1;
      else if (m_n > 0)  m_left <= m_n - 1;
      if (m_stall)       m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      longint sum;
      sum = longint'(m_cnt) + longint'(m_bias);
      if (sum > 65535) sum = 65535;
      check("m_pcwrite",   {31'd0, PCWrite},     {31'd0, !m_stall});
      check("m_ifidwrite", {31'd0, IFIDWrite},   {31'd0, !m_stall});
      check("m_bubble",    {31'd0, Bubble},      {31'd0, m_stall});
      check("m_pr3rw",     {31'd0, PR3RegWrite}, {31'd0, m_rec[1].rw});
      check("m_pr3rd",     {27'd0, RDfromPR3},   {27'd0, m_rec[1].rd});
      check("m_pr4rw",     {31'd0, PR4RegWrite}, {31'd0, m_rec[2].rw});
      check("m_pr4rd",     {27'd0, RDfromPR4},   {27'd0, m_rec[2].rd});
      check("m_stalls",    {16'd0, StallCycles}, sum[31:0]);
      $display("cyc t=%0t id rs=%0d rt=%0d rd=%0d rw=%0b mr=%0b br=%0b | pc=%0b bub=%0b pr3=%0b/%0d pr4=%0b/%0d sc=%0d",
               $time, IDRS, IDRT, IDRD, IDRegWrite, IDMemRead, IDBranch,
               PCWrite, Bubble, PR3RegWrite, RDfromPR3, PR4RegWrite, RDfromPR4, StallCycles);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic br);
    IDRS = rs; IDRT = rt; IDRD = rd;
    IDRegWrite = rw; IDMemRead = mr; IDBranch = br;
  endtask

  task automatic flush();
    put(0, 0, 0, 0, 0, 0);
    repeat (3) step();
  endtask

  initial begin
    put(0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    step(); step();
    #1;
    check("rst_pcwrite", {31'd0, PCWrite}, 32'd1);
    check("rst_ifid",    {31'd0, IFIDWrite}, 32'd1);
    check("rst_bubble",  {31'd0, Bubble}, 32'd0);
    check("rst_pr3rw",   {31'd0, PR3RegWrite}, 32'd0);
    check("rst_pr4rw",   {31'd0, PR4RegWrite}, 32'd0);
    check("rst_count",   {16'd0, StallCycles}, 32'd0);
    rst = 1'b0;
    step();

    // Load-use: lw $5 then add rs=5.
    put(1, 2, 5, 1, 1, 0);
    step();
    put(5, 6, 8, 1, 0, 0);
    #1;
    check("lu_pcwrite", {31'd0, PCWrite}, 32'd0);
    check("lu_ifid",    {31'd0, IFIDWrite}, 32'd0);
    check("lu_bubble",  {31'd0, Bubble}, 32'd1);
    step(); #1;
    check("lu_resume",  {31'd0, PCWrite}, 32'd1);
    check("lu_count",   {16'd0, StallCycles}, 32'd1);
    check("lu_lw_mem",  {27'd0, RDfromPR3}, 32'd5);
    step(); #1;
    check("lu_bubble_mem", {31'd0, PR3RegWrite}, 32'd0);
    flush();

    // Register 0 never stalls.
    put(0, 0, 0, 1, 1, 0);
    step();
    put(0, 0, 4, 1, 0, 0);
    #1;
    check("r0_pcwrite", {31'd0, PCWrite}, 32'd1);
    flush();

    // Propagation of rd=7 to PR3 then PR4.
    put(1, 2, 7, 1, 0, 0);
    step();
    put(0, 0, 0, 0, 0, 0);
    step(); #1;
    check("prop_pr3rd", {27'd0, RDfromPR3}, 32'd7);
    check("prop_pr3rw", {31'd0, PR3RegWrite}, 32'd1);
    step(); #1;
    check("prop_pr4rd", {27'd0, RDfromPR4}, 32'd7);
    check("prop_pr4rw", {31'd0, PR4RegWrite}, 32'd1);
    flush();

    // Branch after load: two stalls with the branch option, one without.
    put(0, 0, 3, 1, 1, 0);
    step();
    put(3, 4, 0, 0, 0, 1);
    #1;
    check("br_c0", {31'd0, PCWrite}, 32'd0);
    step(); #1;
    check("br_c1", {31'd0, PCWrite}, BR_EN ? 32'd0 : 32'd1);
    step(); #1;
    check("br_c2", {31'd0, PCWrite}, 32'd1);
    check("br_count", {16'd0, StallCycles}, BR_EN ? 32'd3 : 32'd2);
    flush();

    // Branch after ALU producer in EX.
    put(0, 0, 9, 1, 0, 0);
    step();
    put(9, 0, 0, 0, 0, 1);
    #1;
    check("br_alu", {31'd0, PCWrite}, BR_EN ? 32'd0 : 32'd1);
    step();
    flush();

    // Branch after load that has reached MEM.
    put(0, 0, 10, 1, 1, 0);
    step();
    put(0, 0, 0, 0, 0, 0);
    step();
    put(0, 10, 0, 0, 0, 1);
    #1;
    check("br_memld", {31'd0, PCWrite}, BR_EN ? 32'd0 : 32'd1);
    step();
    flush();

    // Reset asserted in the second stall cycle.
    put(0, 0, 3, 1, 1, 0);
    step();
    put(3, 0, 0, 0, 0, 1);
    step();
    rst = 1'b1;
    #1;
    check("rs_pcwrite", {31'd0, PCWrite}, 32'd1);
    check("rs_bubble",  {31'd0, Bubble}, 32'd0);
    check("rs_pr3rw",   {31'd0, PR3RegWrite}, 32'd0);
    check("rs_pr3rd",   {27'd0, RDfromPR3}, 32'd0);
    check("rs_pr4rw",   {31'd0, PR4RegWrite}, 32'd0);
    check("rs_pr4rd",   {27'd0, RDfromPR4}, 32'd0);
    check("rs_count",   {16'd0, StallCycles}, 32'd0);
    step();
    rst = 1'b0;
    put(0, 0, 0, 0, 0, 0);
    #1;
    check("rs_after0", {31'd0, PCWrite}, 32'd1);
    step(); #1;
    check("rs_after1", {31'd0, PCWrite}, 32'd1);

    // Saturation: preload the counter near the top, then keep stalling.
    step();
    m_bias = 65530 - m_cnt;
    force dut.stall_cnt = 16'hFFFA;
    #1 release dut.stall_cnt;
    put(5, 5, 5, 1, 1, 0);
    repeat (20) step();
    #1;
    check("sat_count", {16'd0, StallCycles}, 32'h0000FFFF);
    step(); step(); #1;
    check("sat_hold", {16'd0, StallCycles}, 32'h0000FFFF);
    flush();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  pipeline clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 IDRS  in  5  rs field of the instruction in IF/ID.
REQ-005 IDRT  in  5  rt field of the instruction in IF/ID.
REQ-006 IDRD  in  5  destination register of the ID instruction, after RegDst mux.
REQ-007 IDRegWrite  in  1  ID instruction writes the register file.
REQ-008 IDMemRead  in  1  ID instruction is a load.
REQ-009 IDBranch  in  1  ID instruction is a branch compared in ID.
REQ-010 PCWrite  out  1  PC update enable.
REQ-011 IFIDWrite  out  1  IF/ID pipeline register enable.
REQ-012 Bubble  out  1  zero ID/EX control fields this cycle.
REQ-013 PR3RegWrite, RDfromPR3  out  1, 5  EX/MEM write enable and destination, feeding the forwarding unit.
REQ-014 PR4RegWrite, RDfromPR4  out  1, 5  MEM/WB write enable and destination, feeding the forwarding unit.
REQ-015 StallCycles  out  16  count of stall cycles since reset.

Function
REQ-016 The block SHALL keep shadow stage records EX, MEM and WB of {RegWrite, MemRead, RD}.
REQ-017 Each clock: WB<=MEM, MEM<=EX, EX<={IDRegWrite, IDMemRead, IDRD}; when Bubble=1, EX<=all zero.
REQ-018 PR3RegWrite/RDfromPR3 SHALL be MEM.RegWrite/MEM.RD, and PR4RegWrite/RDfromPR4 SHALL be WB.RegWrite/WB.RD, registered with no combinational path from inputs.
REQ-019 Load-use hazard SHALL be detected when EX.MemRead=1, EX.RD!=0 and EX.RD equals IDRS or IDRT; it requires a stall length N=1.
REQ-020 Register 0 SHALL never cause a hazard.
REQ-021 FSM states: RUN and STALL, with a 2-bit counter CNT.
REQ-022 In RUN with a hazard of length N: stall outputs asserted this cycle; if N>1, go to STALL with CNT=N-1, else stay in RUN.
REQ-023 In STALL: stall outputs asserted; CNT decrements each cycle; return to RUN when CNT reaches 1 and decrements. Hazard inputs are ignored while in STALL.
REQ-024 Stall outputs SHALL be PCWrite=0, IFIDWrite=0 and Bubble=1; otherwise PCWrite=1, IFIDWrite=1 and Bubble=0.
REQ-025 StallCycles SHALL increment on every stalled cycle and saturate at 16'hFFFF.
REQ-026 When several hazards apply simultaneously, the largest N SHALL be used.

Reset
REQ-027 Reset SHALL clear EX, MEM and WB to zero, set the FSM to RUN with CNT=0, and set StallCycles=0.
REQ-028 During and after reset: PR3RegWrite=0, PR4RegWrite=0, RDfromPR3=0, RDfromPR4=0, PCWrite=1, IFIDWrite=1, Bubble=0.
REQ-029 Reset asserted mid-stall SHALL abort the stall immediately, with no residual stall cycles.

Configuration
REQ-030 Macro HAZARD_BRANCH_STALL_EN.
REQ-031 With the macro defined, and IDBranch=1, matching rs or rt against a nonzero RD (largest N applies):
- EX.RegWrite & !EX.MemRead match: N=1.
- EX.MemRead match: N=2.
- MEM.MemRead match: N=1.
REQ-032 Without the macro, IDBranch SHALL be ignored and only the load-use rule applies; the FSM never enters STALL.

Verification
REQ-033 Load-use: lw $5 in EX, ID add rs=5 -> exactly one cycle of PCWrite=0, IFIDWrite=0, Bubble=1; next cycle EX record is zero; StallCycles=1.
REQ-034 Register 0: lw $0 in EX, ID rs=0 -> no stall, PCWrite=1.
REQ-035 Propagation: ID add rd=7, RegWrite=1, no stalls -> RDfromPR3=7 with PR3RegWrite=1 two edges later; RDfromPR4=7 with PR4RegWrite=1 three edges later.
REQ-036 Branch (macro on): lw $3 in EX, ID beq rs=3 -> two consecutive stall cycles, then RUN, StallCycles=2. Macro off -> one stall cycle.
REQ-037 Reset mid-stall: reset asserted in the STALL cycle -> PCWrite=1 immediately, state RUN, all PR outputs 0, StallCycles=0.
REQ-038 Saturation: force 65540 stall cycles -> StallCycles holds at 16'hFFFF.
